// File: rtl/conquest_pkg.sv
// Shared types and word-layout constants for the stimulus sequencer.
package conquest_pkg;

  localparam int unsigned STIM_DATA_W = 8;
  localparam int unsigned STIM_DEPTH  = 11;
  localparam int unsigned STIM_ADDR_W = 4;
  localparam int unsigned STIM_PC_W   = 32;

  // Memory word is {obs, in}
  localparam int unsigned OBS_BIT = STIM_DATA_W;
  localparam int unsigned IN_MSB  = STIM_DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/stim_sequencer_if.sv
// Valid/ready vector channel from the sequencer to the DUT pins.
interface stim_sequencer_if
  import conquest_pkg::*;
#(
  parameter int unsigned DATA_W = STIM_DATA_W
);

  logic              stim_valid;
  logic              stim_ready;
  logic [DATA_W-1:0] stim_in;
  logic              stim_obs;

  modport master (
    output stim_valid,
    output stim_in,
    output stim_obs,
    input  stim_ready
  );

  modport slave (
    input  stim_valid,
    input  stim_in,
    input  stim_obs,
    output stim_ready
  );

endinterface

// File: rtl/stim_sequencer_mem.sv
// Stimulus store: single address port, write or registered read per cycle.
module stim_mem #(
  parameter int unsigned WORD_W = 9,
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Array write; out-of-range addresses are dropped
  always_ff @(posedge clock) begin
    if (we && (32'(addr) < DEPTH)) begin
      mem[addr] <= wdata;
    end
  end

  // Read register doubles as the vector output, so it only updates on re
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: replays stored {obs, in} vectors to the DUT with
// start/pause/abort control, optional looping and a valid/ready handshake.
module stim_sequencer
  import conquest_pkg::*;
#(
  parameter int unsigned DATA_W = STIM_DATA_W,
  parameter int unsigned DEPTH  = STIM_DEPTH,
  parameter int unsigned ADDR_W = STIM_ADDR_W,
  parameter int unsigned PC_W   = STIM_PC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W:0]   load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  stim_sequencer_if.master  stim,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = DATA_W + 1;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  state_e            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [LEN_W-1:0]  len, len_d;
  logic              loop_mode, loop_mode_d;
  logic [PC_W-1:0]   pc_d;
  logic              valid, valid_d;
  logic              busy_d;
  logic              done_d;
  logic              rd_en_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [WORD_W-1:0] rdata;

  // Loads are only honoured while no run is active
  assign wr_en_c    = load_en && ((state == IDLE) || (state == DONE));
  assign mem_addr_c = wr_en_c ? load_addr : addr;

  stim_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (wr_en_c),
    .re    (rd_en_c),
    .addr  (mem_addr_c),
    .wdata (load_data),
    .rdata (rdata)
  );

  assign stim.stim_valid = valid;
  assign stim.stim_in    = rdata[DATA_W-1:0];
  assign stim.stim_obs   = rdata[DATA_W];

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      loop_mode <= 1'b0;
      pc        <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      len       <= len_d;
      loop_mode <= loop_mode_d;
      pc        <= pc_d;
      valid     <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and output decode; abort beats everything, pause freezes
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    len_d       = len;
    loop_mode_d = loop_mode;
    pc_d        = pc;
    valid_d     = valid;
    done_d      = done;
    rd_en_c     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (!pause) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_d       = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
            loop_mode_d = loop_en;
            addr_d      = '0;
            pc_d        = '0;
            done_d      = 1'b0;
            if (len_d == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          rd_en_c = 1'b1;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: begin
          if (stim.stim_ready) begin
            pc_d    = pc + PC_W'(1);
            valid_d = 1'b0;
            if ({1'b0, addr} == (len - LEN_W'(1))) begin
              addr_d = '0;
              if (loop_mode) begin
                state_d = FETCH;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              addr_d  = addr + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == FETCH) || (state_d == ISSUE);
  end

endmodule
